// File: rtl/uart_tx_top.sv
// UART transmitter: oversample tick generator plus serial frame FSM (start, LSB-first data, stop).
// Define UART_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module uart_tx_top #(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int BAUD_RATE = 19_200,
    parameter int DIVISOR   = (CLK_FREQ + 8 * BAUD_RATE) / (16 * BAUD_RATE),
    parameter int DBIT      = 8,
    parameter int SB_TICK   = 16,
`ifdef UART_PARITY_EN
    parameter int NB_STATE  = 3
`else
    parameter int NB_STATE  = 2
`endif
) (
    input  logic            i_clock,
    input  logic            i_reset,
    input  logic            i_tx_start,
    input  logic [DBIT-1:0] i_data,
    output logic            o_tx_2
);

    localparam int CW = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
    localparam int SW = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;
    localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;

    localparam logic [CW-1:0] TICK_LAST = CW'(DIVISOR - 1);
    localparam logic [SW-1:0] BIT_LAST  = SW'(15);
    localparam logic [SW-1:0] STOP_LAST = SW'(SB_TICK - 1);
    localparam logic [NW-1:0] DATA_LAST = NW'(DBIT - 1);

    typedef enum logic [NB_STATE-1:0] {
        S_IDLE   = NB_STATE'(0),
        S_START  = NB_STATE'(1),
        S_DATA   = NB_STATE'(2),
`ifdef UART_PARITY_EN
        S_STOP   = NB_STATE'(3),
        S_PARITY = NB_STATE'(4)
`else
        S_STOP   = NB_STATE'(3)
`endif
    } t_state;

    t_state            r_state;
    t_state            w_state_next;
    logic [CW-1:0]     r_tick_cnt;
    logic [SW-1:0]     r_s;
    logic [SW-1:0]     w_s_next;
    logic [NW-1:0]     r_n;
    logic [NW-1:0]     w_n_next;
    logic [DBIT-1:0]   r_b;
    logic [DBIT-1:0]   w_b_next;
    logic              r_tx;
    logic              w_tx_next;
    logic              w_tick;
    logic              w_accept;

    assign w_tick   = (r_tick_cnt == TICK_LAST);
    assign w_accept = (r_state == S_IDLE) && i_tx_start;
    assign o_tx_2   = r_tx;

    // Clearing on accept aligns every bit to exactly 16 full tick periods.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_tick_cnt <= '0;
        end else if (w_accept || w_tick) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + 1'b1;
        end
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state <= S_IDLE;
            r_s     <= '0;
            r_n     <= '0;
            r_b     <= '0;
            r_tx    <= 1'b1;
        end else begin
            r_state <= w_state_next;
            r_s     <= w_s_next;
            r_n     <= w_n_next;
            r_b     <= w_b_next;
            r_tx    <= w_tx_next;
        end
    end

`ifdef UART_PARITY_EN
    logic r_par;
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_par <= 1'b0;
        end else if (w_accept) begin
            r_par <= ^i_data;
        end
    end
`endif

    // The line value is computed for the next state so o_tx_2 stays a plain register.
    always_comb begin
        w_state_next = r_state;
        w_s_next     = r_s;
        w_n_next     = r_n;
        w_b_next     = r_b;
        w_tx_next    = r_tx;
        case (r_state)
            S_IDLE: begin
                w_tx_next = 1'b1;
                if (i_tx_start) begin
                    w_state_next = S_START;
                    w_s_next     = '0;
                    w_n_next     = '0;
                    w_b_next     = i_data;
                    w_tx_next    = 1'b0;
                end
            end
            S_START: begin
                if (w_tick) begin
                    if (r_s == BIT_LAST) begin
                        w_state_next = S_DATA;
                        w_s_next     = '0;
                        w_n_next     = '0;
                        w_tx_next    = r_b[0];
                    end else begin
                        w_s_next = r_s + 1'b1;
                    end
                end
            end
            S_DATA: begin
                if (w_tick) begin
                    if (r_s == BIT_LAST) begin
                        w_s_next = '0;
                        w_b_next = r_b >> 1;
                        if (r_n == DATA_LAST) begin
`ifdef UART_PARITY_EN
                            w_state_next = S_PARITY;
                            w_tx_next    = r_par;
`else
                            w_state_next = S_STOP;
                            w_tx_next    = 1'b1;
`endif
                        end else begin
                            w_n_next  = r_n + 1'b1;
                            w_tx_next = r_b[1];
                        end
                    end else begin
                        w_s_next = r_s + 1'b1;
                    end
                end
            end
`ifdef UART_PARITY_EN
            S_PARITY: begin
                if (w_tick) begin
                    if (r_s == BIT_LAST) begin
                        w_state_next = S_STOP;
                        w_s_next     = '0;
                        w_tx_next    = 1'b1;
                    end else begin
                        w_s_next = r_s + 1'b1;
                    end
                end
            end
`endif
            S_STOP: begin
                if (w_tick) begin
                    if (r_s == STOP_LAST) begin
                        w_state_next = S_IDLE;
                        w_s_next     = '0;
                        w_tx_next    = 1'b1;
                    end else begin
                        w_s_next = r_s + 1'b1;
                    end
                end
            end
            default: begin
                w_state_next = S_IDLE;
                w_tx_next    = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx_top.sv
// Bench for uart_tx_top: a frame-level line model is compared every cycle, plus literal frame patterns.
module tb_uart_tx_top;

    // A short divisor keeps every frame cheap to simulate; bit length scales as 16*DIVISOR.
    localparam int TB_DIV = 7;
    localparam int BIT    = 16 * TB_DIV;
    localparam int FRAME  = 10 * BIT;

    logic       clk   = 1'b0;
    logic       rst   = 1'b1;
    logic       start = 1'b0;
    logic [7:0] data  = 8'h00;
    logic       tx;

    int compared   = 0;
    int mismatched = 0;

    always #10 clk = ~clk;

    uart_tx_top #(.DIVISOR(TB_DIV)) dut (
        .i_clock    (clk),
        .i_reset    (rst),
        .i_tx_start (start),
        .i_data     (data),
        .o_tx_2     (tx)
    );

    // Line model: after acceptance, cycle c of the frame shows frame bit c/BIT.
    logic       m_busy  = 1'b0;
    int         m_cnt   = 0;
    logic [9:0] m_frame = 10'h3FF;
    logic       m_exp   = 1'b1;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy <= 1'b0;
            m_exp  <= 1'b1;
        end else if (!m_busy) begin
            if (start) begin
                m_busy  <= 1'b1;
                m_cnt   <= 0;
                m_frame <= {1'b1, data, 1'b0};
                m_exp   <= 1'b0;
            end else begin
                m_exp <= 1'b1;
            end
        end else if (m_cnt + 1 == FRAME) begin
            m_busy <= 1'b0;
            m_exp  <= 1'b1;
        end else begin
            m_cnt <= m_cnt + 1;
            m_exp <= m_frame[(m_cnt + 1) / BIT];
        end
    end

    always @(negedge clk) begin
        compared++;
        if (tx !== m_exp) begin
            mismatched++;
            $display("FAIL model_line t=%0t: got %b want %b", $time, tx, m_exp);
        end
    end

    task automatic check(input string name, input logic act, input logic exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %b want %b", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #5;
    endtask

    task automatic wait_fall(output int n);
        n = 0;
        for (int i = 0; i < 4 * BIT; i++) begin
            @(negedge clk);
            n++;
            if (tx === 1'b0) return;
        end
        mismatched++;
        $display("FAIL wait_fall: line never fell within %0d cycles", 4 * BIT);
    endtask

    // Called at the first negedge showing the start bit; samples the middle of each bit.
    task automatic check_bits(input string name, input logic [9:0] pat);
        for (int k = 0; k < 10; k++) begin
            repeat ((k == 0) ? BIT / 2 : BIT) @(negedge clk);
            check($sformatf("%s_bit%0d", name, k), tx, pat[k]);
        end
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 3 * FRAME; i++) begin
            @(negedge clk);
            if (!m_busy) return;
        end
        mismatched++;
        $display("FAIL wait_idle: frame did not end within %0d cycles", 3 * FRAME);
    endtask

    task automatic send_check(input string name, input logic [7:0] d, input int len,
                              input logic [9:0] pat);
        int n;
        step();
        data  = d;
        start = 1'b1;
        fork
            begin
                repeat (len) step();
                start = 1'b0;
            end
            begin
                wait_fall(n);
                check_int({name, "_latency"}, n, 2);
                check_bits(name, pat);
            end
        join
        wait_idle();
    endtask

    initial begin
        int n;
        int lows;
        int len;

        // Reset held with a pending request: line stays idle.
        start = 1'b1;
        data  = 8'h55;
        repeat (20) begin
            @(negedge clk);
            check("reset_hold", tx, 1'b1);
        end

        // Release reset with start already high: frame begins on the first edge.
        step();
        rst = 1'b0;
        wait_fall(n);
        check_int("release_latency", n, 2);
        start = 1'b0;
        check_bits("frame_55", 10'b10_1010_1010);
        wait_idle();

        send_check("frame_01", 8'h01, 5, 10'b10_0000_0010);
        send_check("frame_20", 8'h20, 1, 10'b10_0100_0000);

        // Mid-frame data change and start pulse are ignored.
        step();
        data  = 8'hA3;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (3 * BIT) step();
        data  = 8'h00;
        start = 1'b1;
        repeat (5) step();
        start = 1'b0;
        data  = 8'hFF;
        wait_idle();
        lows = 0;
        repeat (2 * BIT) begin
            @(negedge clk);
            if (tx === 1'b0) lows++;
        end
        check_int("no_second_frame", lows, 0);

        // Reset during DATA aborts the frame immediately.
        step();
        data  = 8'hC5;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (4 * BIT) step();
        rst = 1'b1;
        #1;
        check("reset_abort", tx, 1'b1);
        repeat (3) step();
        rst = 1'b0;
        repeat (2 * BIT) step();
        send_check("after_reset", 8'h3C, 2, 10'b10_0111_1000);

        // Randomized traffic: gaps, pulse lengths, held start (back-to-back), data churn.
        for (int it = 0; it < 16; it++) begin
            repeat ($urandom_range(0, BIT)) step();
            data  = 8'($urandom);
            start = 1'b1;
            len = ($urandom_range(0, 3) == 0) ? FRAME + int'($urandom_range(1, BIT))
                                              : int'($urandom_range(1, 4));
            repeat (len) step();
            start = 1'b0;
            repeat ($urandom_range(0, 3)) begin
                repeat ($urandom_range(1, BIT)) step();
                data = 8'($urandom);
            end
            wait_idle();
            $display("random frame %0d done (start held %0d cycles)", it, len);
        end

        repeat (4) step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
